pwm_capture: RTL and testbench
==============================

# pwm_capture

Duty-cycle and period capture stage that sits directly downstream of the programmable PWM core and consumes one of its PWM output lines. It measures the high time and period of each PWM cycle in clock cycles and presents each result on a valid/ready handshake. Used in the top-level bench and on-chip loopback to check the PWM generator against its programmed settings.

## Interface
- `CNT_W`, default 16: width of the high-time and period counters and result fields.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ena`  in  1  block enable; low forces capture FSM to IDLE; pending result retained.
- `clear`  in  1  synchronous clear: FSM to IDLE, drops pending result, clears `dropped`.
- `pwm_in`  in  1  PWM line from the PWM core.
- `meas_valid`  out  1  result held on `high_cnt`/`period_cnt`/`meas_ovf`.
- `meas_ready`  in  1  consumer accepts result when `meas_valid && meas_ready`.
- `high_cnt`  out  CNT_W  high time of measured cycle, clock cycles.
- `period_cnt`  out  CNT_W  rising edge to next rising edge, clock cycles.
- `meas_ovf`  out  1  result saturated (counter hit all-ones).
- `dropped`  out  1  sticky: a completed measurement was discarded because output was full.
- `busy`  out  1  FSM not in IDLE.

## Operation
- Input path: `pwm_s` = `pwm_in` (see Configuration); `pwm_q` = `pwm_s` delayed one cycle. Rise = `pwm_s & ~pwm_q`; fall = `~pwm_s & pwm_q`. `pwm_q` resets to 0.
- FSM states: IDLE, HIGH, LOW.
  - IDLE: on rise -> HIGH, `period_ctr`=1, `high_ctr`=1.
  - HIGH: each cycle both counters +1; on fall -> LOW (`high_ctr` frozen, `period_ctr` +1).
  - LOW: `period_ctr` +1; on rise -> emit result, `period_ctr`=1, `high_ctr`=1, -> HIGH (back-to-back cycles measured with no gap).
- Example: pwm high 3 cycles, low 7 cycles, repeating -> `high_cnt`=3, `period_cnt`=10.
- Saturation: if `period_ctr` reaches 2^CNT_W-1 in HIGH or LOW, emit result with `meas_ovf`=1, `period_cnt`=all-ones, `high_cnt`=current `high_ctr` (saturating), -> IDLE. Constant-high or constant-low input thus gives an overflow result then waits for a new rise.
- Emit: if output empty, or full and accepted this same cycle, load result and set `meas_valid`. Otherwise discard new result, set `dropped`; held result unchanged.
- Held result is stable while `meas_valid && !meas_ready`.
- `clear` has priority over `ena`, which has priority over emit; `clear` and an emit in the same cycle -> nothing emitted.

## Timing
- Reset values: `meas_valid`=0, `high_cnt`=0, `period_cnt`=0, `meas_ovf`=0, `dropped`=0, `busy`=0, FSM IDLE, counters 0.
- Latency: `meas_valid` rises the cycle after `pwm_s` shows the closing rise (plus synchronizer delay if compiled in).
- Handshake: transfer on `meas_valid && meas_ready` at clock edge; `meas_valid` drops next cycle unless a new result loads in the same edge.
- Reset mid-measurement: all state cleared immediately (async); first result after reset requires a fresh rise.
- `ena` low mid-measurement: partial measurement discarded; next result needs a rise after `ena` returns high.
- Minimum measurable: high 1, period 2.

## Configuration
- `PWM_CAPTURE_SYNC_EN` defined: `pwm_in` passes through a two-flop synchronizer (reset 0) before `pwm_s`; adds 2 cycles latency, measured values unchanged. Undefined: `pwm_s` = `pwm_in` directly (input assumed synchronous to `clk`).

## Test plan
- Periodic 3 high / 7 low, `meas_ready`=1 -> each result `high_cnt`=3, `period_cnt`=10, `meas_ovf`=0, one result per 10 cycles.
- 1 high / 1 low -> `high_cnt`=1, `period_cnt`=2 on every result.
- `meas_ready`=0 over three PWM periods (5/5) -> first result held stable, `dropped`=1; after `clear`, `meas_valid`=0 and `dropped`=0.
- CNT_W=8, rise then constant high -> result `meas_ovf`=1, `period_cnt`=255, `high_cnt`=255, `busy`=0 afterwards.
- Assert `rst_n`=0 mid-HIGH -> all outputs 0 same cycle; after release, first result only after next full rise-to-rise period.
- With `PWM_CAPTURE_SYNC_EN`: 4/6 pattern -> `high_cnt`=4, `period_cnt`=10, `meas_valid` 2 cycles later than without macro.

Source files
------------

// File: rtl/pwm_capture.sv
// pwm_capture
// Measures the high time and period (rising edge to rising edge) of each
// cycle on a PWM line, in clock cycles, and offers each result on a
// single-entry valid/ready output register.
//
// Optional feature: define PWM_CAPTURE_SYNC_EN to pass pwm_in through a
// two-flop synchronizer first (adds 2 cycles latency, values unchanged).
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   ena           enable; low parks the FSM in IDLE (held result kept)
//   clear         synchronous clear of FSM, held result and dropped flag
//   pwm_in        PWM line
//   meas_valid    result held on high_cnt / period_cnt / meas_ovf
//   meas_ready    consumer accept
//   high_cnt      measured high time
//   period_cnt    measured period
//   meas_ovf      result saturated at all-ones
//   dropped       sticky: a finished measurement was lost (output full)
//   busy          FSM not in IDLE
module pwm_capture #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             clear,
    input  logic             pwm_in,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic             meas_ovf,
    output logic             dropped,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state, state_nxt;
    logic [CNT_W-1:0] high_ctr, period_ctr, high_nxt, period_nxt;
    logic             pwm_s, pwm_q, rise, fall;
    logic             emit, emit_ovf;

`ifdef PWM_CAPTURE_SYNC_EN
    logic sync1, sync2;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= pwm_in;
            sync2 <= sync1;
        end
    end
    assign pwm_s = sync2;
`else
    assign pwm_s = pwm_in;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pwm_q <= 1'b0;
        else        pwm_q <= pwm_s;
    end

    assign rise = pwm_s & ~pwm_q;
    assign fall = ~pwm_s & pwm_q;
    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            high_ctr   <= '0;
            period_ctr <= '0;
        end else begin
            state      <= state_nxt;
            high_ctr   <= high_nxt;
            period_ctr <= period_nxt;
        end
    end

    // The emitted result is always the current counter contents; on
    // saturation period_ctr is already all-ones and high_ctr <= period_ctr.
    always_comb begin
        state_nxt  = state;
        high_nxt   = high_ctr;
        period_nxt = period_ctr;
        emit       = 1'b0;
        emit_ovf   = 1'b0;
        if (clear || !ena) begin
            state_nxt  = IDLE;
            high_nxt   = '0;
            period_nxt = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (rise) begin
                        state_nxt  = HIGH;
                        high_nxt   = CNT_ONE;
                        period_nxt = CNT_ONE;
                    end
                end
                HIGH: begin
                    if (period_ctr == CNT_MAX) begin
                        emit      = 1'b1;
                        emit_ovf  = 1'b1;
                        state_nxt = IDLE;
                    end else if (fall) begin
                        state_nxt  = LOW;
                        period_nxt = period_ctr + CNT_ONE;
                    end else begin
                        high_nxt   = high_ctr + CNT_ONE;
                        period_nxt = period_ctr + CNT_ONE;
                    end
                end
                LOW: begin
                    if (period_ctr == CNT_MAX) begin
                        emit      = 1'b1;
                        emit_ovf  = 1'b1;
                        state_nxt = IDLE;
                    end else if (rise) begin
                        // closing rise also opens the next cycle: no gap
                        emit       = 1'b1;
                        state_nxt  = HIGH;
                        high_nxt   = CNT_ONE;
                        period_nxt = CNT_ONE;
                    end else begin
                        period_nxt = period_ctr + CNT_ONE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Single-entry output register. A new result may replace one that is
    // being accepted on the same edge; otherwise it is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meas_valid <= 1'b0;
            high_cnt   <= '0;
            period_cnt <= '0;
            meas_ovf   <= 1'b0;
            dropped    <= 1'b0;
        end else if (clear) begin
            meas_valid <= 1'b0;
            dropped    <= 1'b0;
        end else if (emit) begin
            if (!meas_valid || meas_ready) begin
                meas_valid <= 1'b1;
                high_cnt   <= high_ctr;
                period_cnt <= period_ctr;
                meas_ovf   <= emit_ovf;
            end else begin
                dropped <= 1'b1;
            end
        end else if (meas_valid && meas_ready) begin
            meas_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Testbench for pwm_capture (CNT_W=8). The reference model tracks the
// cycle index of the opening rise and of the fall of the cycle being
// measured and derives each result arithmetically from those indices.
module tb_pwm_capture;

    localparam int CNT_W = 8;
    localparam int MAX   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             ena = 1'b0;
    logic             clear = 1'b0;
    logic             pwm_in = 1'b0;
    logic             meas_ready = 1'b0;
    logic             meas_valid;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] period_cnt;
    logic             meas_ovf;
    logic             dropped;
    logic             busy;

    pwm_capture #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .clear     (clear),
        .pwm_in    (pwm_in),
        .meas_valid(meas_valid),
        .meas_ready(meas_ready),
        .high_cnt  (high_cnt),
        .period_cnt(period_cnt),
        .meas_ovf  (meas_ovf),
        .dropped   (dropped),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // reference model state
    int cyc, t0, tf;      // current cycle, opening rise (-1: none), fall (-1: none)
    bit prev, s1, s2;
    bit m_vld, m_ovf, m_drop;
    int m_h, m_p;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        cyc = 0; t0 = -1; tf = -1;
        prev = 0; s1 = 0; s2 = 0;
        m_vld = 0; m_ovf = 0; m_drop = 0; m_h = 0; m_p = 0;
    endtask

    task automatic model_edge();
        bit eff, rise, fall, em, eo;
        int eh, ep;
`ifdef PWM_CAPTURE_SYNC_EN
        eff = s2; s2 = s1; s1 = pwm_in;
`else
        eff = pwm_in;
`endif
        rise = eff && !prev;
        fall = !eff && prev;
        em = 0; eo = 0; eh = 0; ep = 0;
        if (clear || !ena) begin
            t0 = -1;
        end else if (t0 >= 0) begin
            if (cyc - t0 == MAX) begin
                em = 1; eo = 1; ep = MAX;
                eh = (tf >= 0) ? tf - t0 : MAX;
                t0 = -1;
            end else if (rise) begin
                em = 1; eh = tf - t0; ep = cyc - t0;
                t0 = cyc; tf = -1;
            end else if (fall) begin
                tf = cyc;
            end
        end else if (rise) begin
            t0 = cyc; tf = -1;
        end
        if (clear) begin
            m_vld = 0; m_drop = 0;
        end else if (em) begin
            if (!m_vld || meas_ready) begin
                m_vld = 1; m_h = eh; m_p = ep; m_ovf = eo;
            end else begin
                m_drop = 1;
            end
        end else if (m_vld && meas_ready) begin
            m_vld = 0;
        end
        prev = eff;
        cyc++;
    endtask

    task automatic check_outputs();
        chk("valid",   32'(meas_valid), 32'(m_vld));
        chk("high",    32'(high_cnt),   32'(m_h));
        chk("period",  32'(period_cnt), 32'(m_p));
        chk("ovf",     32'(meas_ovf),   32'(m_ovf));
        chk("dropped", 32'(dropped),    32'(m_drop));
        chk("busy",    32'(busy),       32'(t0 >= 0));
    endtask

    task automatic step(input bit p, input bit rdy);
        pwm_in = p;
        meas_ready = rdy;
        @(posedge clk);
        model_edge();
        #1 check_outputs();
    endtask

    task automatic run(input int h, input int l, input int n, input bit rdy);
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < h; i++) step(1'b1, rdy);
            for (int i = 0; i < l; i++) step(1'b0, rdy);
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step(1'b0, 1'b1);
        clear = 1'b0;
        step(1'b0, 1'b1);
    endtask

    initial begin
        model_reset();
        #1;
        chk("rst_valid",  32'(meas_valid), 0);
        chk("rst_high",   32'(high_cnt),   0);
        chk("rst_period", 32'(period_cnt), 0);
        chk("rst_ovf",    32'(meas_ovf),   0);
        chk("rst_drop",   32'(dropped),    0);
        chk("rst_busy",   32'(busy),       0);
        @(negedge clk);
        rst_n = 1'b1;
        ena   = 1'b1;

        // 3 high / 7 low, always ready
        run(3, 7, 5, 1'b1);
        chk("p37_high",   32'(high_cnt),   3);
        chk("p37_period", 32'(period_cnt), 10);
        chk("p37_ovf",    32'(meas_ovf),   0);

        // minimum pulse: 1 high / 1 low
        do_clear();
        run(1, 1, 6, 1'b1);
        chk("p11_high",   32'(high_cnt),   1);
        chk("p11_period", 32'(period_cnt), 2);

        // consumer stalled over three 5/5 periods
        do_clear();
        run(5, 5, 3, 1'b0);
        step(1'b1, 1'b0);
        chk("stall_valid",  32'(meas_valid), 1);
        chk("stall_high",   32'(high_cnt),   5);
        chk("stall_period", 32'(period_cnt), 10);
        chk("stall_drop",   32'(dropped),    1);
        clear = 1'b1;
        step(1'b0, 1'b0);
        clear = 1'b0;
        chk("clr_valid", 32'(meas_valid), 0);
        chk("clr_drop",  32'(dropped),    0);

        // rise then constant high saturates
        do_clear();
        for (int i = 0; i < 300; i++) step(1'b1, 1'b1);
        chk("sat_ovf",    32'(meas_ovf),   1);
        chk("sat_period", 32'(period_cnt), MAX);
        chk("sat_high",   32'(high_cnt),   MAX);
        chk("sat_busy",   32'(busy),       0);

        // saturation while low
        do_clear();
        run(2, 270, 1, 1'b1);
        chk("satl_ovf",  32'(meas_ovf), 1);
        chk("satl_high", 32'(high_cnt), 2);

        // async reset in the middle of a high phase
        do_clear();
        run(4, 4, 2, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid",  32'(meas_valid), 0);
        chk("arst_high",   32'(high_cnt),   0);
        chk("arst_period", 32'(period_cnt), 0);
        chk("arst_busy",   32'(busy),       0);
        pwm_in = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        run(2, 3, 3, 1'b1);

        // randomized segments, ready, enable and clear
        for (int seg = 0; seg < 120; seg++) begin
            int h, l;
            h = $urandom_range(1, 12);
            l = $urandom_range(1, 12);
            for (int i = 0; i < h + l; i++) begin
                ena   = ($urandom_range(0, 59) != 0);
                clear = ($urandom_range(0, 149) == 0);
                step(i < h, $urandom_range(0, 3) != 0);
            end
        end
        ena = 1'b1;
        clear = 1'b0;
        run(4, 6, 3, 1'b1);
        chk("end_high",   32'(high_cnt),   4);
        chk("end_period", 32'(period_cnt), 10);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
